mp3_tag_lookup: RTL

//  Tag-lookup stage that directly drives the 32x23 single-port tag SRAM (mp3_tag_array_2) and consumes its dout.

---
 rtl/mp3_tag_lookup.sv | 102 ++++++++++
 1 files changed

// File: rtl/mp3_tag_lookup.sv
// mp3_tag_lookup: tag-lookup stage driving the 32x23 tag SRAM, with per-set valid/dirty and hit/victim response
module mp3_tag_lookup #(
  parameter int TAG_WIDTH   = 23,
  parameter int SET_BITS    = 5,
  parameter int OFFSET_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic                 req_write,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [SET_BITS-1:0]  resp_set,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_dirty,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [SET_BITS-1:0]  fill_set,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 fill_dirty,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic [SET_BITS-1:0]  sram_addr,
  output logic [TAG_WIDTH-1:0] sram_din,
  input  logic [TAG_WIDTH-1:0] sram_dout
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
  state_t                 state;
  logic [(1<<SET_BITS)-1:0] valid, dirty;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [SET_BITS-1:0]    set_q;
  logic                   write_q;
  logic [SET_BITS-1:0]    req_set;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   idle, fill_go, req_go, lookup_hit;
  logic                   unused_offset;
  assign req_set       = req_addr[OFFSET_BITS +: SET_BITS];
  assign req_tag       = req_addr[OFFSET_BITS+SET_BITS +: TAG_WIDTH];
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];
  // Handshake and SRAM controls; the SRAM is only enabled in an accept cycle, fill wins over lookup
  always_comb begin
    idle       = state == IDLE;
    fill_go    = idle && fill_valid;
    req_go     = idle && req_valid && !fill_valid;
    fill_ready = idle;
    req_ready  = idle && !fill_valid;
    sram_csb   = !(fill_go || req_go);
    sram_web   = !fill_go;
    sram_addr  = fill_go ? fill_set : req_set;
    sram_din   = fill_tag;
    lookup_hit = valid[set_q] && (sram_dout == tag_q);
  end
  // Control FSM with registered response and the valid/dirty flops the SRAM cannot reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      tag_q      <= '0;
      set_q      <= '0;
      write_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_set   <= '0;
      resp_tag   <= '0;
      resp_dirty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_valid) begin
            valid[fill_set] <= 1'b1;
            dirty[fill_set] <= fill_dirty;
          end else if (req_valid) begin
            tag_q   <= req_tag;
            set_q   <= req_set;
            write_q <= req_write;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_hit   <= lookup_hit;
          resp_tag   <= sram_dout;
          resp_dirty <= dirty[set_q];
          resp_set   <= set_q;
          resp_valid <= 1'b1;
          if (write_q && lookup_hit) dirty[set_q] <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
